// File: rtl/store_pack_buffer.sv
// ---------------------------------------------------------------------------
// store_pack_buffer
//   Narrows CPU store data (byte / halfword / word) onto the little-endian
//   byte lanes of a 32-bit data-memory word and generates byte enables.
//   Accepted stores are queued in a DEPTH-entry FIFO and drained to data
//   memory over a req/ack handshake. Misaligned or reserved-size stores
//   complete the handshake but are dropped, and st_misalign_o is raised
//   for the following cycle.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   st_valid_i     store request from the MEM stage
//   st_size_i      00 byte, 01 halfword, 10 word, 11 reserved
//   st_addr_i      byte address
//   st_data_i      register data (low byte / halfword used for narrow sizes)
//   st_ready_o     request accepted this cycle (FIFO not full)
//   st_misalign_o  previous accepted request was rejected
//   mem_req_o      write request to data memory
//   mem_addr_o     word address, bits [1:0] always 0
//   mem_wdata_o    lane-replicated write data
//   mem_be_o       byte enables, bit k covers bits [8k+7:8k]
//   mem_ack_i      memory accepted the write (only looked at while mem_req_o)
//   empty_o        FIFO empty and no write outstanding
//
// Drain FSM
//   state  | meaning
//   S_IDLE | nothing queued, mem_req_o low
//   S_BUSY | head entry presented to memory, waiting for mem_ack_i
// ---------------------------------------------------------------------------
module store_pack_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        st_valid_i,
    input  logic [1:0]  st_size_i,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    output logic        st_ready_o,
    output logic        st_misalign_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    output logic        empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic           misalign_q;

    logic [29:0]    fifo_addr_q  [DEPTH];
    logic [31:0]    fifo_wdata_q [DEPTH];
    logic [3:0]     fifo_be_q    [DEPTH];

    logic [31:0]    pk_wdata;
    logic [3:0]     pk_be;
    logic           pk_reject;
    logic           accept, push, pop;

    // ready is purely a function of registered occupancy: a pop on a full
    // edge does not open a slot for a push on that same edge.
    assign st_ready_o = (count_q != CW'(DEPTH));
    assign accept     = st_valid_i && st_ready_o;
    assign push       = accept && !pk_reject;
    assign pop        = (state_q == S_BUSY) && mem_ack_i;

    always_comb begin
        pk_wdata  = '0;
        pk_be     = '0;
        pk_reject = 1'b0;
        unique case (st_size_i)
            2'b00: begin
                pk_wdata = {4{st_data_i[7:0]}};
                pk_be    = 4'b0001 << st_addr_i[1:0];
            end
            2'b01: begin
                pk_wdata  = {2{st_data_i[15:0]}};
                pk_be     = st_addr_i[1] ? 4'b1100 : 4'b0011;
                pk_reject = st_addr_i[0];
            end
            2'b10: begin
                pk_wdata  = st_data_i;
                pk_be     = 4'b1111;
                pk_reject = (st_addr_i[1:0] != 2'b00);
            end
            default: begin
                pk_reject = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // A push into an idle buffer moves straight to BUSY so the request is
    // visible the cycle after acceptance; a push on the edge that pops the
    // last entry keeps the FSM in BUSY.
    always_comb begin
        state_d   = state_q;
        mem_req_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_d != '0) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_req_o = 1'b1;
                if (pop && (count_d == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            misalign_q <= accept && pk_reject;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i]  <= '0;
                fifo_wdata_q[i] <= '0;
                fifo_be_q[i]    <= '0;
            end
        end else if (push) begin
            fifo_addr_q[wr_ptr_q]  <= st_addr_i[31:2];
            fifo_wdata_q[wr_ptr_q] <= pk_wdata;
            fifo_be_q[wr_ptr_q]    <= pk_be;
        end
    end

    // Memory-side outputs are held at zero while idle so the port is quiet
    // between bursts and at reset.
    assign mem_addr_o    = mem_req_o ? {fifo_addr_q[rd_ptr_q], 2'b00} : 32'h0;
    assign mem_wdata_o   = mem_req_o ? fifo_wdata_q[rd_ptr_q] : 32'h0;
    assign mem_be_o      = mem_req_o ? fifo_be_q[rd_ptr_q] : 4'h0;
    assign st_misalign_o = misalign_q;
    assign empty_o       = (count_q == '0) && !mem_req_o;

endmodule
